call_stack: RTL and testbench



---
 rtl/call_stack.sv | 107 ++++++++++
 tb/tb_call_stack.sv | 138 +++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// rtl/call_stack.sv - return-address stack holding {pc, flags} entries for the DRFA CPU
module call_stack #(
    parameter int DEPTH      = 16,
    parameter int PC_WIDTH   = 9,
    parameter int FLAG_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_push_en,
    input  logic                   in_pop_en,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic [FLAG_WIDTH-1:0]  in_flags,
    input  logic                   in_clear_err,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [FLAG_WIDTH-1:0]  out_flags,
    output logic [$clog2(DEPTH):0] out_depth,
    output logic                   out_empty,
    output logic                   out_full,
    output logic                   out_overflow,
    output logic                   out_underflow
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int SP_W    = IDX_W + 1;
    localparam int ENTRY_W = PC_WIDTH + FLAG_WIDTH;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]    sp_q, sp_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [ENTRY_W-1:0] wr_data;
    logic [IDX_W-1:0]   top_idx;
    logic [ENTRY_W-1:0] top_entry;
    logic               empty, full;

    assign empty     = (sp_q == '0);
    assign full      = (sp_q == SP_FULL);
    assign top_idx   = IDX_W'(sp_q - SP_W'(1));
    assign top_entry = mem_q[top_idx];

    always_comb begin
        sp_d    = sp_q;
        ovf_d   = ovf_q & ~in_clear_err;
        unf_d   = unf_q & ~in_clear_err;
        wr_en   = 1'b0;
        wr_idx  = sp_q[IDX_W-1:0];
        wr_data = {in_pc, in_flags};
        case ({in_push_en, in_pop_en})
            2'b10: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + SP_W'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    sp_d = sp_q - SP_W'(1);
                end
            end
            2'b11: begin
                // Empty push+pop still flags the bad pop, then the push lands at index 0.
                if (empty) begin
                    unf_d = 1'b1;
                    wr_en = 1'b1;
                    sp_d  = SP_W'(1);
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is not reset; reads are gated on empty so stale data never leaks out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign out_pc        = empty ? '0 : top_entry[ENTRY_W-1:FLAG_WIDTH];
    assign out_flags     = empty ? '0 : top_entry[FLAG_WIDTH-1:0];
    assign out_depth     = sp_q;
    assign out_empty     = empty;
    assign out_full      = full;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - directed vector bench for call_stack
module tb_call_stack;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0, pop = 1'b0, clr = 1'b0;
    logic [8:0] pc = '0;
    logic [3:0] fl = '0;
    logic [8:0] o_pc;
    logic [3:0] o_fl;
    logic [4:0] o_depth;
    logic       o_empty, o_full, o_ovf, o_unf;

    int tests = 0;
    int fails = 0;

    call_stack #(.DEPTH(16), .PC_WIDTH(9), .FLAG_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_push_en(push), .in_pop_en(pop),
        .in_pc(pc), .in_flags(fl), .in_clear_err(clr),
        .out_pc(o_pc), .out_flags(o_fl), .out_depth(o_depth),
        .out_empty(o_empty), .out_full(o_full),
        .out_overflow(o_ovf), .out_underflow(o_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push, pop, clr;
        logic [8:0] pc;
        logic [3:0] fl;
        logic [8:0] e_pc;
        logic [3:0] e_fl;
        logic [4:0] e_d;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] e_pc, input logic [3:0] e_fl,
                           input logic [4:0] e_d, input logic e_ovf, input logic e_unf);
        chk({tag, ".pc"}, int'(o_pc), int'(e_pc));
        chk({tag, ".flags"}, int'(o_fl), int'(e_fl));
        chk({tag, ".depth"}, int'(o_depth), int'(e_d));
        chk({tag, ".empty"}, int'(o_empty), int'(e_d == 5'd0));
        chk({tag, ".full"}, int'(o_full), int'(e_d == 5'd16));
        chk({tag, ".ovf"}, int'(o_ovf), int'(e_ovf));
        chk({tag, ".unf"}, int'(o_unf), int'(e_unf));
    endtask

    task automatic step(input logic s_push, input logic s_pop, input logic s_clr,
                        input logic [8:0] s_pc, input logic [3:0] s_fl);
        push = s_push; pop = s_pop; clr = s_clr; pc = s_pc; fl = s_fl;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0; pc = '0; fl = '0;
    endtask

    initial begin
        //            push pop  clr  pc      fl       e_pc    e_fl     e_d  ovf  unf
        vec[0]  = '{1'b1, 1'b0, 1'b0, 9'h1E1, 4'b1001, 9'h1E1, 4'b1001, 5'd1, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 1'b0, 9'h020, 4'b0101, 9'h020, 4'b0101, 5'd2, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 1'b1, 1'b0, 9'h000, 4'b0000, 9'h1E1, 4'b1001, 5'd1, 1'b0, 1'b0};
        vec[3]  = '{1'b0, 1'b1, 1'b0, 9'h000, 4'b0000, 9'h000, 4'b0000, 5'd0, 1'b0, 1'b0};
        vec[4]  = '{1'b0, 1'b1, 1'b0, 9'h000, 4'b0000, 9'h000, 4'b0000, 5'd0, 1'b0, 1'b1};
        vec[5]  = '{1'b0, 1'b0, 1'b1, 9'h000, 4'b0000, 9'h000, 4'b0000, 5'd0, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 9'h000, 4'b0000, 9'h000, 4'b0000, 5'd0, 1'b0, 1'b1};
        vec[7]  = '{1'b0, 1'b0, 1'b1, 9'h000, 4'b0000, 9'h000, 4'b0000, 5'd0, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 9'h011, 4'b0011, 9'h011, 4'b0011, 5'd1, 1'b0, 1'b0};
        vec[9]  = '{1'b1, 1'b0, 1'b0, 9'h022, 4'b0110, 9'h022, 4'b0110, 5'd2, 1'b0, 1'b0};
        vec[10] = '{1'b1, 1'b1, 1'b0, 9'h0AA, 4'b1111, 9'h0AA, 4'b1111, 5'd2, 1'b0, 1'b0};
        vec[11] = '{1'b0, 1'b1, 1'b0, 9'h000, 4'b0000, 9'h011, 4'b0011, 5'd1, 1'b0, 1'b0};
        vec[12] = '{1'b0, 1'b1, 1'b0, 9'h000, 4'b0000, 9'h000, 4'b0000, 5'd0, 1'b0, 1'b0};
        vec[13] = '{1'b1, 1'b1, 1'b0, 9'h0AA, 4'b0010, 9'h0AA, 4'b0010, 5'd1, 1'b0, 1'b1};
        vec[14] = '{1'b0, 1'b1, 1'b1, 9'h000, 4'b0000, 9'h000, 4'b0000, 5'd0, 1'b0, 1'b0};

        #12;
        chk_all("reset", 9'h0, 4'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("idle", 9'h0, 4'h0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(vec[i].push, vec[i].pop, vec[i].clr, vec[i].pc, vec[i].fl);
            chk_all($sformatf("vec%0d", i), vec[i].e_pc, vec[i].e_fl, vec[i].e_d,
                    vec[i].e_ovf, vec[i].e_unf);
        end

        // Fill to full, overflow, then drain in LIFO order.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 9'(i), 4'(i));
        chk_all("full", 9'd15, 4'd15, 5'd16, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 9'h1FF, 4'hA);
        chk_all("overflow", 9'd15, 4'd15, 5'd16, 1'b1, 1'b0);
        for (int i = 15; i >= 0; i--) begin
            chk($sformatf("drain%0d.pc", i), int'(o_pc), i);
            chk($sformatf("drain%0d.flags", i), int'(o_fl), i);
            step(1'b0, 1'b1, 1'b0, 9'h0, 4'h0);
        end
        chk_all("drained", 9'h0, 4'h0, 5'd0, 1'b1, 1'b0);

        // Push+pop at full replaces the top without overflow.
        step(1'b0, 1'b0, 1'b1, 9'h0, 4'h0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 9'(i + 32), 4'(i));
        step(1'b1, 1'b1, 1'b0, 9'h0AA, 4'h5);
        chk_all("full_pushpop", 9'h0AA, 4'h5, 5'd16, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 9'h0, 4'h0);
        chk_all("full_pushpop_below", 9'd46, 4'd14, 5'd15, 1'b0, 1'b0);

        // Asynchronous reset in the middle of the high phase at depth 3.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 9'(i + 100), 4'(i));
        chk("pre_reset.depth", int'(o_depth), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 9'h0, 4'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 9'h0, 4'h0);
        chk_all("post_reset_pop", 9'h0, 4'h0, 5'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 9'h155, 4'hC);
        chk_all("post_reset_push", 9'h155, 4'hC, 5'd1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
